// File: rtl/alu_exec_unit.sv
// ALU execute unit: single-cycle logic/arithmetic ops, bit-serial shifter.
// Valid/ready on both sides; result, Zero and tag held until consumed.
module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    input  logic [4:0]        in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Zero,
    output logic [4:0]        out_rd,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_cnt;
    logic [DATA_W-1:0] r_work;
    logic [1:0]        r_kind;
    logic [4:0]        r_rd_sh;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic [4:0]        r_out_rd;

    logic              w_is_shift;
    logic [4:0]        w_shamt;
    logic              w_accept;
    logic              w_start_shift;
    logic              w_last;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_step;

    assign w_is_shift    = (Operation[3:2] == 2'b11) &&
                           (Operation[1:0] != 2'b11);
    assign w_shamt       = SrcB[4:0];
    assign w_accept      = in_valid && in_ready;
    assign w_start_shift = w_accept && w_is_shift && (w_shamt != 5'd0);
    assign w_last        = (r_state == SHIFT) && (r_cnt <= 5'd1);

    assign in_ready  = reset && (r_state == IDLE) &&
                       (!r_out_valid || out_ready) && !flush;
    assign busy      = (r_state == SHIFT);
    assign out_valid = r_out_valid;
    assign ALUResult = r_result;
    assign Zero      = r_zero;
    assign out_rd    = r_out_rd;

    // Zero-amount shifts fall through here and return SrcA in one cycle.
    always_comb begin
        w_alu = '0;
        case (Operation)
            4'b0000: w_alu = SrcA & SrcB;
            4'b0001: w_alu = SrcA | SrcB;
            4'b0010: w_alu = SrcA ^ SrcB;
            4'b0100: w_alu = SrcA + SrcB;
            4'b0101: w_alu = SrcA - SrcB;
            4'b1000: w_alu = {{(DATA_W-1){1'b0}}, (SrcA == SrcB)};
            4'b1100,
            4'b1101,
            4'b1110: w_alu = SrcA;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_step = r_work;
        case (r_kind)
            2'b00:   w_step = {r_work[DATA_W-2:0], 1'b0};
            2'b01:   w_step = {1'b0, r_work[DATA_W-1:1]};
            2'b10:   w_step = {r_work[DATA_W-1], r_work[DATA_W-1:1]};
            default: w_step = r_work;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_start_shift) w_state_nxt = SHIFT;
            SHIFT: if (w_last)        w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_work      <= '0;
            r_kind      <= '0;
            r_rd_sh     <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_out_rd    <= '0;
        end else if (flush) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // A result registered below overrides this consume.
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            if (r_state == SHIFT) begin
                r_work <= w_step;
                if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
                if (w_last) begin
                    r_result    <= w_step;
                    r_zero      <= (w_step == '0);
                    r_out_rd    <= r_rd_sh;
                    r_out_valid <= 1'b1;
                end
            end else if (w_start_shift) begin
                r_work  <= SrcA;
                r_cnt   <= w_shamt;
                r_kind  <= Operation[1:0];
                r_rd_sh <= in_rd;
            end else if (w_accept) begin
                r_result    <= w_alu;
                r_zero      <= (w_alu == '0);
                r_out_rd    <= in_rd;
                r_out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: transaction-level model compared every cycle,
// directed literal cases, then randomized traffic with backpressure/flush.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b1;
    logic [3:0]    Operation = '0;
    logic [W-1:0]  SrcA = '0;
    logic [W-1:0]  SrcB = '0;
    logic [4:0]    in_rd = '0;
    logic          in_ready;
    logic          out_valid;
    logic          Zero;
    logic          busy;
    logic [W-1:0]  ALUResult;
    logic [4:0]    out_rd;

    alu_exec_unit #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .in_rd(in_rd),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero), .out_rd(out_rd),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int k;
        k = int'(b[4:0]);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a ^ b;
            4'd4:    return a + b;
            4'd5:    return a - b;
            4'd8:    return (a == b) ? 1 : 0;
            4'd12:   return a << k;
            4'd13:   return a >> k;
            4'd14:   return W'($signed(a) >>> k);
            default: return '0;
        endcase
    endfunction

    // Model: a held result plus a countdown for a pending multi-cycle shift.
    logic          m_ov   = 1'b0;
    logic [W-1:0]  m_res  = '0;
    logic [4:0]    m_rd   = '0;
    int            m_wait = 0;
    logic [W-1:0]  m_pres = '0;
    logic [4:0]    m_prd  = '0;

    function automatic logic exp_ready();
        return reset && (m_wait == 0) && (!m_ov || out_ready) && !flush;
    endfunction

    always @(posedge clk or negedge reset) begin : model
        logic          v;
        logic          acc;
        logic [W-1:0]  r;
        logic [4:0]    t;
        int            w;
        logic [W-1:0]  pr;
        logic [4:0]    pt;
        v = m_ov; r = m_res; t = m_rd; w = m_wait; pr = m_pres; pt = m_prd;
        if (!reset) begin
            v = 1'b0; r = '0; t = '0; w = 0;
        end else if (flush) begin
            v = 1'b0; w = 0;
        end else begin
            acc = in_valid && exp_ready();
            if (v && out_ready) v = 1'b0;
            if (w > 0) begin
                w--;
                if (w == 0) begin
                    v = 1'b1; r = m_pres; t = m_prd;
                end
            end else if (acc) begin
                if ((Operation inside {4'd12, 4'd13, 4'd14}) &&
                    (SrcB[4:0] != 5'd0)) begin
                    w  = int'(SrcB[4:0]);
                    pr = ref_alu(Operation, SrcA, SrcB);
                    pt = in_rd;
                end else begin
                    v = 1'b1;
                    r = ref_alu(Operation, SrcA, SrcB);
                    t = in_rd;
                end
            end
        end
        m_ov <= v; m_res <= r; m_rd <= t; m_wait <= w;
        m_pres <= pr; m_prd <= pt;
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_result", ALUResult, 0);
            chk("rst_zero", Zero, 1);
            chk("rst_out_rd", out_rd, 0);
        end else begin
            chk("in_ready", in_ready, exp_ready());
            chk("busy", busy, (m_wait > 0));
            chk("out_valid", out_valid, m_ov);
            if (m_ov) begin
                chk("result", ALUResult, m_res);
                chk("zero", Zero, (m_res == '0));
                chk("out_rd", out_rd, m_rd);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] rd,
                         output bit ok);
        Operation = op; SrcA = a; SrcB = b; in_rd = rd; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        if (!ok) chk("issue_timeout", 0, 1);
    endtask

    task automatic run(input string name, input logic [3:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd, input logic [W-1:0] exp,
                       input int lat, output int nb);
        bit ok;
        bit got;
        int n;
        out_ready = 1'b1;
        issue(op, a, b, rd, ok);
        n = 0; got = 1'b0; nb = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (out_valid) got = 1'b1;
        end
        chk({name, "_lat"}, n, lat);
        chk({name, "_res"}, ALUResult, exp);
        chk({name, "_zero"}, Zero, (exp == '0));
        chk({name, "_rd"}, out_rd, rd);
        @(posedge clk); #1;
    endtask

    logic [3:0] ops [12] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8,
                             4'd12, 4'd13, 4'd14, 4'd3, 4'd7, 4'd15};

    initial begin : stim
        int  nb;
        bit  ok;
        bit  seen;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        run("add", 4'd4, 32'h7FFFFFFF, 32'd1, 5'd1, 32'h80000000, 1, nb);
        run("sub", 4'd5, 32'd5, 32'd5, 5'd2, 32'h0, 1, nb);
        run("eq", 4'd8, 32'hDEAD, 32'hDEAD, 5'd3, 32'h1, 1, nb);
        run("sra", 4'd14, 32'h80000000, 32'd4, 5'd4, 32'hF8000000, 5, nb);
        chk("sra_busy_cycles", nb, 4);
        run("sll31", 4'd12, 32'd1, 32'd31, 5'd5, 32'h80000000, 32, nb);
        run("sll0", 4'd12, 32'h1234ABCD, 32'h20, 5'd6, 32'h1234ABCD, 1, nb);
        run("undef", 4'd7, 32'h1357, 32'h2468, 5'd8, 32'h0, 1, nb);

        // Backpressure: result held while a second op waits.
        out_ready = 1'b0;
        issue(4'd0, 32'hF0F0, 32'h0FF0, 5'd7, ok);
        Operation = 4'd1; SrcA = 32'd1; SrcB = 32'd2; in_rd = 5'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_result", ALUResult, 32'h00F0);
            chk("bp_rd", out_rd, 7);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp2_valid", out_valid, 1);
        chk("bp2_result", ALUResult, 32'd3);
        chk("bp2_rd", out_rd, 3);
        @(posedge clk); #1;

        // Flush two cycles into an SRL by 10.
        issue(4'd13, 32'hFFFF0000, 32'd10, 5'd9, ok);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_result", seen, 0);
        @(posedge clk); #1;

        // Reset in the middle of an SLL by 20.
        issue(4'd12, 32'd3, 32'd20, 5'd4, ok);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_result", ALUResult, 0);
        chk("mid_rst_zero", Zero, 1);
        chk("mid_rst_rd", out_rd, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("post_rst_no_result", seen, 0);
        @(posedge clk); #1;

        for (int c = 0; c < 1500; c++) begin
            in_valid  = (($urandom % 3) != 0);
            Operation = ops[$urandom % 12];
            SrcA      = $urandom;
            SrcB      = $urandom;
            if (($urandom % 4) == 0) SrcB = SrcA;
            if (Operation[3:2] == 2'b11)
                SrcB[4:0] = (($urandom % 8) == 0) ? 5'd31 :
                            5'($urandom_range(0, 6));
            in_rd     = 5'($urandom);
            out_ready = (($urandom % 4) != 0);
            flush     = (($urandom % 50) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
